// File: rtl/csa_pkg.sv
// Shared constants and tree-depth helper for the multi-operand carry-save adder.
package csa_pkg;

  localparam int unsigned CSA_MAX_IN = 8;
  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned CSA_IDX_W  = $clog2(CSA_MAX_IN);

  // Each level turns every full group of three rows into two; leftover rows pass through.
  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned cnt;
    int unsigned lvl;
    cnt = n;
    lvl = 0;
    for (int unsigned i = 0; i < CSA_MAX_IN; i++) begin
      if (cnt > 2) begin
        cnt = 2 * (cnt / 3) + (cnt % 3);
        lvl = lvl + 1;
      end
    end
    return lvl;
  endfunction

endpackage

// File: rtl/csa_tree_nto2.sv
// Combinational N_IN:2 carry-save reduction built from 3:2 cells, levels unrolled at elaboration.
module csa_tree_nto2
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N_IN  = 4
) (
  input  logic [N_IN*WIDTH-1:0] ops_i,
  output logic [WIDTH-1:0]      sum_o,
  output logic [WIDTH-1:0]      carry_o
);

  localparam int unsigned LEVELS = csa_levels(N_IN);

  logic [WIDTH-1:0] vec [CSA_MAX_IN];
  logic [WIDTH-1:0] nxt [CSA_MAX_IN];
  logic [WIDTH-1:0] a, b, c;
  int unsigned      cnt;
  int unsigned      grp;
  int unsigned      rem;

  always_comb begin
    for (int unsigned i = 0; i < CSA_MAX_IN; i++) begin
      vec[i] = '0;
      nxt[i] = '0;
    end
    a   = '0;
    b   = '0;
    c   = '0;
    grp = 0;
    rem = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      vec[k] = ops_i[k*WIDTH +: WIDTH];
    end
    cnt = N_IN;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      grp = cnt / 3;
      rem = cnt % 3;
      for (int unsigned i = 0; i < CSA_MAX_IN; i++) begin
        nxt[i] = '0;
      end
      for (int unsigned g = 0; g < CSA_MAX_IN / 3; g++) begin
        if (g < grp) begin
          a = vec[CSA_IDX_W'(3*g)];
          b = vec[CSA_IDX_W'(3*g+1)];
          c = vec[CSA_IDX_W'(3*g+2)];
          nxt[CSA_IDX_W'(2*g)]   = a ^ b ^ c;
          // carry shifted up one place; the bit leaving the top is dropped (mod 2^WIDTH)
          nxt[CSA_IDX_W'(2*g+1)] = ((a & b) | (a & c) | (b & c)) << 1;
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (r < rem) begin
          nxt[CSA_IDX_W'(2*grp+r)] = vec[CSA_IDX_W'(3*grp+r)];
        end
      end
      for (int unsigned i = 0; i < CSA_MAX_IN; i++) begin
        vec[i] = nxt[i];
      end
      cnt = 2 * grp + rem;
    end
    sum_o   = vec[0];
    carry_o = vec[1];
  end

endmodule

// File: rtl/csa_add_pipe_nx.sv
// Pipelined masked multi-operand modular adder: CSA tree, optional tree register, CPA output stage.
module csa_add_pipe_nx
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned REG_TREE = 1,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_IN*WIDTH-1:0] in_data_i,
  input  logic [N_IN-1:0]       in_mask_i,
  input  logic [TAG_W-1:0]      in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_sum_o,
  output logic [TAG_W-1:0]      out_tag_o
);

  logic [N_IN*WIDTH-1:0] masked_ops;
  logic [WIDTH-1:0]      tree_s;
  logic [WIDTH-1:0]      tree_c;

  always_comb begin
    masked_ops = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (in_mask_i[k]) begin
        masked_ops[k*WIDTH +: WIDTH] = in_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  csa_tree_nto2 #(
    .WIDTH(WIDTH),
    .N_IN (N_IN)
  ) u_tree (
    .ops_i  (masked_ops),
    .sum_o  (tree_s),
    .carry_o(tree_c)
  );

  logic             src_valid;
  logic [WIDTH-1:0] src_s;
  logic [WIDTH-1:0] src_c;
  logic [TAG_W-1:0] src_tag;

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_sum_q,   o_sum_d;
  logic [TAG_W-1:0] o_tag_q,   o_tag_d;
  logic             o_ready;

  assign o_ready = !o_valid_q | out_ready_i;

  generate
    if (REG_TREE != 0) begin : g_tree_reg
      logic             t_valid_q, t_valid_d;
      logic [WIDTH-1:0] t_s_q,     t_s_d;
      logic [WIDTH-1:0] t_c_q,     t_c_d;
      logic [TAG_W-1:0] t_tag_q,   t_tag_d;
      logic             t_ready;

      // Accepts while the output stage drains in the same cycle (pass-through).
      assign t_ready = !t_valid_q | o_ready;

      always_comb begin
        t_valid_d = t_valid_q;
        t_s_d     = t_s_q;
        t_c_d     = t_c_q;
        t_tag_d   = t_tag_q;
        if (t_ready) begin
          t_valid_d = in_valid_i;
          if (in_valid_i) begin
            t_s_d   = tree_s;
            t_c_d   = tree_c;
            t_tag_d = in_tag_i;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          t_valid_q <= 1'b0;
          t_s_q     <= '0;
          t_c_q     <= '0;
          t_tag_q   <= '0;
        end else begin
          t_valid_q <= t_valid_d;
          t_s_q     <= t_s_d;
          t_c_q     <= t_c_d;
          t_tag_q   <= t_tag_d;
        end
      end

      assign src_valid  = t_valid_q;
      assign src_s      = t_s_q;
      assign src_c      = t_c_q;
      assign src_tag    = t_tag_q;
      assign in_ready_o = t_ready;
    end else begin : g_tree_comb
      assign src_valid  = in_valid_i;
      assign src_s      = tree_s;
      assign src_c      = tree_c;
      assign src_tag    = in_tag_i;
      assign in_ready_o = o_ready;
    end
  endgenerate

  always_comb begin
    o_valid_d = o_valid_q;
    o_sum_d   = o_sum_q;
    o_tag_d   = o_tag_q;
    if (o_ready) begin
      o_valid_d = src_valid;
      if (src_valid) begin
        o_sum_d = src_s + src_c;
        o_tag_d = src_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_sum_q   <= '0;
      o_tag_q   <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_sum_q   <= o_sum_d;
      o_tag_q   <= o_tag_d;
    end
  end

  assign out_valid_o = o_valid_q;
  assign out_sum_o   = o_sum_q;
  assign out_tag_o   = o_tag_q;

endmodule
